// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - bstart/bdone bus initiator: one core request per bus transaction
module bus_master_port #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              bstart,
  output logic              ss,
  output logic              ttype,
  output logic [1:0]        tsize,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              bdone
);

  // Counter wide enough to reach TIMEOUT-1; LAST is the count at which an unanswered transaction aborts.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_error;
  logic [CW-1:0]     r_cnt;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_on_bus;
  logic              w_timeout;
  logic [31:0]       w_repl;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_misaligned = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_on_bus     = (r_state == S_START) || (r_state == S_WAIT);
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == LAST);

  // Store data is replicated across every lane so the slave can pick its lane by address.
  always_comb begin
    w_repl = req_wdata;
    case (req_size)
      2'd0:    w_repl = {4{req_wdata[7:0]}};
      2'd1:    w_repl = {2{req_wdata[15:0]}};
      default: w_repl = req_wdata;
    endcase
  end

  // Pick the addressed lane(s) out of the slave data and extend to 32 bits.
  always_comb begin
    w_byte = rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = r_addr[1] ? rdata[31:16] : rdata[15:0];
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a misaligned request skips the bus and goes straight to the response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_misaligned ? S_RESP : S_START;
      S_START: w_next = (bdone || w_timeout) ? S_RESP : S_WAIT;
      S_WAIT:  if (bdone || w_timeout) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, read capture on the bdone cycle, and the timeout counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_error  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= w_repl;
      r_rdata  <= 32'd0;
      r_error  <= w_misaligned;
      r_cnt    <= '0;
    end else if (w_on_bus) begin
      if (bdone) begin
        r_rdata <= r_write ? 32'd0 : w_ext;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (w_timeout) r_error <= 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'd0;
  assign resp_error = resp_valid & r_error;
  assign bstart     = (r_state == S_START);
  assign ss         = w_on_bus;
  assign ttype      = w_on_bus & r_write;
  assign tsize      = w_on_bus ? r_size : 2'd0;
  assign addr       = w_on_bus ? r_addr : '0;
  assign wdata      = w_on_bus ? r_wdata : 32'd0;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - self-checking bench for bus_master_port
module tb_bus_master_port;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        bstart, ss, ttype;
  logic [1:0]  tsize;
  logic [31:0] addr, wdata, rdata;
  logic        bdone;

  bus_master_port #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .bstart(bstart), .ss(ss), .ttype(ttype),
    .tsize(tsize), .addr(addr), .wdata(wdata), .rdata(rdata), .bdone(bdone)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  int          o_resp_n, o_ss_cnt, o_bs_cnt, o_bs_first, o_fields_bad, o_ready_bad;
  logic [31:0] o_rdata;
  logic        o_err;

  typedef struct {
    logic        w;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_ss;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd3) return 1'b1;
    return (a % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [1:0] size, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Issue one request and play a slave that raises bdone `lat` cycles after bstart.
  task automatic run_txn(input logic w, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int lat, input logic [31:0] e_wd);
    int guard = 0;
    int k = -1;
    int n = 1;
    bit done = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_size = size; req_signed = sgn;
    req_addr = a; req_wdata = wd; rdata = rd; bdone = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_write = 1'($urandom); req_signed = 1'($urandom);
    o_resp_n = 0; o_ss_cnt = 0; o_bs_cnt = 0; o_bs_first = 0;
    o_fields_bad = 0; o_ready_bad = 0; o_rdata = 32'hX; o_err = 1'bX;
    while (!done && n <= 20) begin
      if (ss) begin
        k++;
        o_ss_cnt++;
        if (ttype !== w || tsize !== size || addr !== a) o_fields_bad++;
        if (w && wdata !== e_wd) o_fields_bad++;
      end else if (ttype !== 1'b0 || bstart !== 1'b0) begin
        o_fields_bad++;
      end
      if (bstart) begin
        o_bs_cnt++;
        if (o_bs_first == 0) o_bs_first = n;
      end
      if (req_ready) o_ready_bad++;
      if (resp_valid) begin
        o_resp_n = n; o_rdata = resp_rdata; o_err = resp_error; done = 1;
      end
      bdone = ss && (k == lat);
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    bdone = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int e_lat, input int e_ss,
                           input logic [31:0] e_rd, input logic e_err);
    chk({tag, " resp_lat"}, 32'(o_resp_n), 32'(e_lat));
    chk({tag, " ss_cycles"}, 32'(o_ss_cnt), 32'(e_ss));
    chk({tag, " bstart_cnt"}, 32'(o_bs_cnt), (e_ss > 0) ? 32'd1 : 32'd0);
    chk({tag, " bstart_at"}, 32'(o_bs_first), (e_ss > 0) ? 32'd1 : 32'd0);
    chk({tag, " rdata"}, o_rdata, e_rd);
    chk({tag, " error"}, {31'd0, o_err}, {31'd0, e_err});
    chk({tag, " bus_fields"}, 32'(o_fields_bad), 32'd0);
    chk({tag, " ready_busy"}, 32'(o_ready_bad), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_sz;
    logic        r_w, r_s, mis;
    logic [31:0] r_a, r_wd, r_rd, e_rd;
    int          r_lat, e_lat, e_ss;
    logic        e_err;

    //        w     size  sgn   addr          wdata         rdata         lat e_wdata       e_rdata       err  lat ss
    vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 32'h0,        32'hDEADBEEF, 1'b0, 3, 2};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 1, 32'h0,        32'hFFFFFF80, 1'b0, 3, 2};
    vecs[2] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1, 32'h0,        32'h00000080, 1'b0, 3, 2};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80010000, 1, 32'h0,        32'hFFFF8001, 1'b0, 3, 2};
    vecs[4] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h55AA55AA, 1, 32'hABCDABCD, 32'h0,        1'b0, 3, 2};
    vecs[5] = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h12345678, 1, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[6] = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 0, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1};
    vecs[7] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h12345678, 1, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[8] = '{1'b1, 2'd0, 1'b0, 32'h001, 32'h000000A5, 32'hFFFFFFFF, 2, 32'hA5A5A5A5, 32'h0,        1'b0, 4, 3};
    vecs[9] = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'h1234F00D, 1, 32'h0,        32'h0000F00D, 1'b0, 3, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rdata = 32'd0; bdone = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst ss_bstart_ttype", {29'd0, ss, bstart, ttype}, 32'd0);
    chk("rst resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst addr", addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].w, vecs[i].size, vecs[i].sgn, vecs[i].a, vecs[i].wd, vecs[i].rd,
              vecs[i].lat, vecs[i].e_wd);
      check_txn($sformatf("vec%0d", i), vecs[i].e_lat, vecs[i].e_ss, vecs[i].e_rd, vecs[i].e_err);
    end

    // Timeout with a late bdone afterwards, then a normal transaction.
    run_txn(1'b0, 2'd2, 1'b0, 32'h180, 32'h0, 32'h11111111, 100, 32'h0);
    check_txn("timeout", TMO + 1, TMO, 32'h0, 1'b1);
    @(negedge clk);
    bdone = 1'b1;
    @(negedge clk);
    bdone = 1'b0;
    chk("late_bdone resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("late_bdone ss", {31'd0, ss}, 32'd0);
    chk("late_bdone ready", {31'd0, req_ready}, 32'd1);
    run_txn(1'b0, 2'd2, 1'b0, 32'h184, 32'h0, 32'h76543210, 1, 32'h0);
    check_txn("after_timeout", 3, 2, 32'h76543210, 1'b0);

    // Reset while waiting for the slave.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300; rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst pre ss", {31'd0, ss}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst ss", {31'd0, ss}, 32'd0);
    chk("midrst bstart", {31'd0, bstart}, 32'd0);
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst ready", {31'd0, req_ready}, 32'd1);
    bdone = 1'b1;
    @(negedge clk);
    bdone = 1'b0;
    chk("stray_bdone resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("stray_bdone ss", {31'd0, ss}, 32'd0);
    @(negedge clk);
    chk("stray_bdone resp_valid2", {31'd0, resp_valid}, 32'd0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0BADCAFE, 1, 32'h0);
    check_txn("after_reset", 3, 2, 32'h0BADCAFE, 1'b0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_w = 1'($urandom); r_sz = 2'($urandom); r_s = 1'($urandom);
      r_a = $urandom; r_wd = $urandom; r_rd = $urandom;
      r_lat = $urandom_range(5, 0);
      mis = is_mis(r_sz, r_a);
      if (mis) begin
        e_lat = 1; e_ss = 0; e_rd = 32'h0; e_err = 1'b1;
      end else if (r_lat < TMO) begin
        e_lat = r_lat + 2; e_ss = r_lat + 1; e_err = 1'b0;
        e_rd = r_w ? 32'h0 : ref_rdata(r_sz, r_s, r_a, r_rd);
      end else begin
        e_lat = TMO + 1; e_ss = TMO; e_rd = 32'h0; e_err = 1'b1;
      end
      run_txn(r_w, r_sz, r_s, r_a, r_wd, r_rd, r_lat, ref_wdata(r_sz, r_wd));
      check_txn($sformatf("rnd%0d", i), e_lat, e_ss, e_rd, e_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Initiator-side engine for the SoC's bstart/bdone bus. It sits between a core load/store unit and the bus fabric and turns one core request into one bus transaction. It also applies alignment checks, byte-lane steering, read sign/zero extension and a response timeout. It is the master end of the protocol that the on-chip memories and peripherals implement as slaves.

## Interface
- TIMEOUT, 255, cycles with ss high before an unanswered transaction is aborted; 0 disables the timeout.
- ADDR_W, 32, address width.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = BYTE, 1 = HALF, 2 = WORD; 3 treated as misaligned.
- req_signed  in  1  load sign-extends when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse, no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or timed out.
- bstart  out  1  transaction start pulse.
- ss  out  1  slave select, high for the whole transaction.
- ttype  out  1  READ = 0, WRITE = 1.
- tsize  out  2  same encoding as req_size.
- addr  out  ADDR_W  transaction address, unmodified.
- wdata  out  32  lane-replicated store data.
- rdata  in  32  slave read data, lanes selected by addr[1:0].
- bdone  in  1  slave completion.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: req_ready = 1.
  - On req_valid, latch the request.
  - Aligned request → START.
  - Misaligned request (HALF with addr[0] = 1, WORD with addr[1:0] ≠ 0, or size 3) → RESP with error; no bus activity.
- START: bstart = 1 and ss = 1 for exactly one cycle.
  - bdone = 1 → RESP.
  - Otherwise → WAIT.
- WAIT: ss = 1.
  - bdone = 1 → RESP, capture rdata.
  - Timeout → RESP with error, no capture.
  - Otherwise stay in WAIT.
- RESP: resp_valid = 1 for one cycle → IDLE.
- Bus outputs: addr, ttype, tsize and wdata are driven from the latched request and stay stable from START through the bdone cycle inclusive. Outside START/WAIT, ss, bstart and ttype are 0; addr, tsize and wdata are don't-care.
- wdata lane replication:
  - BYTE: {4{b[7:0]}}.
  - HALF: {2{h[15:0]}}.
  - WORD: unchanged.
- Read extraction:
  - BYTE: rdata lane addr[1:0].
  - HALF: rdata[15:0] when addr[1] = 0, rdata[31:16] when addr[1] = 1.
  - WORD: all 32 bits.
  - Result is sign- or zero-extended per req_signed.
  - Capture happens only on the bdone cycle.
- Timeout counter:
  - Cleared when entering START.
  - Increments in each START/WAIT cycle without bdone.
  - When it reaches TIMEOUT−1 with no bdone (TIMEOUT ≠ 0), next state is RESP with resp_error = 1. ss is therefore high for exactly TIMEOUT cycles.
- bdone outside START/WAIT is ignored.
- rdata is ignored on writes.
- A new request can be accepted only after resp_valid, so there is at most one outstanding transaction.

## Timing
- Reset: with rst_n sampled low, the next edge forces IDLE and clears the counter. All outputs are then 0 except req_ready = 1. This applies mid-transaction too: ss drops and the pending response is discarded.
- Request accepted at edge T (the cycle where req_valid && req_ready):
  - START occupies cycle T+1.
  - With a slave that asserts bdone one cycle after sampling bstart, bdone arrives in cycle T+2 and resp_valid is high in T+3.
  - With a combinational slave (bdone in START), resp_valid is in T+2.
- Misaligned request: resp_valid in T+1.
- Throughput: at most one transaction per 3 cycles; req_ready is low from T+1 until IDLE is re-entered.

## Test plan
- Word read 0x100, slave bdone one cycle after bstart with rdata 0xDEADBEEF → bstart at T+1, ss high T+1..T+2, ttype = 0, tsize = 2, resp_valid at T+3 with 0xDEADBEEF, error = 0.
- Byte load 0x103, rdata 0x80FF0000 → signed gives 0xFFFFFF80; unsigned gives 0x00000080. Half load 0x102, rdata 0x8001_0000, signed → 0xFFFF8001.
- Half store 0x102, req_wdata 0x1234ABCD → wdata 0xABCDABCD, ttype = 1, tsize = 1, addr 0x102; fields stable until bdone; resp_rdata = 0.
- Word load 0x101 → no bstart/ss; resp_valid at T+1 with error = 1 and rdata = 0.
- TIMEOUT = 4, slave never responds → ss high T+1..T+4, resp_valid at T+5 with error = 1. A late bdone at T+6 is ignored, and the next request completes normally.
- rst_n low during WAIT → ss, bstart and resp_valid are 0 after the next edge and req_ready = 1. A subsequent stray bdone produces no response; a fresh word read of 0x200 completes with correct data.
